// File: rtl/clock_ctrl.sv
// Mode/sequencing controller for the hh:mm:ss counter:
// 1 Hz prescaler, set-time/set-alarm FSM, alarm timer.
module clock_ctrl #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int ALARM_LEN = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       alarm_en,
  input  logic [5:0] cur_hours,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       tick,
  output logic       load,
  output logic [5:0] load_hours,
  output logic [5:0] load_min,
  output logic [5:0] load_sec,
  output logic [5:0] alarm_hours,
  output logic [5:0] alarm_min,
  output logic [2:0] mode,
  output logic       alarm
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(ALARM_LEN + 1);
  localparam logic [PW-1:0] PMAX  = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DLAST = DW'(ALARM_LEN - 1);

  typedef enum logic [2:0] {
    S_RUN   = 3'd0,
    S_SET_H = 3'd1,
    S_SET_M = 3'd2,
    S_SET_S = 3'd3,
    S_AL_H  = 3'd4,
    S_AL_M  = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic          r_btn_mode_q;
  logic          r_btn_inc_q;
  logic          r_match_q;
  logic          r_tick;
  logic          r_load;
  logic          r_alarm;
  logic [PW-1:0] r_pre;
  logic [DW-1:0] r_dur;
  logic [5:0]    r_sh, r_sm, r_ss;
  logic [5:0]    r_ah, r_am;

  logic w_mode_p, w_inc_p, w_match, w_trig;
  logic w_load_nx, w_edit_nx;

  function automatic logic [5:0] inc_wrap(
    input logic [5:0] v,
    input logic [5:0] lim
  );
    return (v >= lim) ? 6'd0 : v + 6'd1;
  endfunction

  // A mode press masks a simultaneous inc press.
  assign w_mode_p = btn_mode & ~r_btn_mode_q;
  assign w_inc_p  = btn_inc & ~r_btn_inc_q & ~w_mode_p;

  assign w_match = alarm_en
                 & (cur_hours == r_ah)
                 & (cur_min == r_am)
                 & (cur_sec == 6'd0);
  assign w_trig  = w_match & ~r_match_q;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_RUN:   if (w_mode_p) w_state_nx = S_SET_H;
      S_SET_H: if (w_mode_p) w_state_nx = S_SET_M;
      S_SET_M: if (w_mode_p) w_state_nx = S_SET_S;
      S_SET_S: if (w_mode_p) w_state_nx = S_AL_H;
      S_AL_H:  if (w_mode_p) w_state_nx = S_AL_M;
      S_AL_M:  if (w_mode_p) w_state_nx = S_RUN;
      default: w_state_nx = S_RUN;
    endcase
  end

  assign w_load_nx = w_mode_p & (r_state == S_SET_S);
  assign w_edit_nx = w_state_nx inside {S_SET_H, S_SET_M, S_SET_S};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_RUN;
      r_btn_mode_q <= 1'b0;
      r_btn_inc_q  <= 1'b0;
      r_match_q    <= 1'b0;
      r_tick       <= 1'b0;
      r_load       <= 1'b0;
      r_alarm      <= 1'b0;
      r_pre        <= '0;
      r_dur        <= '0;
      r_sh         <= 6'd0;
      r_sm         <= 6'd0;
      r_ss         <= 6'd0;
      r_ah         <= 6'd0;
      r_am         <= 6'd0;
    end else begin
      r_btn_mode_q <= btn_mode;
      r_btn_inc_q  <= btn_inc;
      r_match_q    <= w_match;
      r_state      <= w_state_nx;
      r_load       <= w_load_nx;

      if (w_mode_p && r_state == S_RUN) begin
        r_sh <= cur_hours;
        r_sm <= cur_min;
        r_ss <= cur_sec;
      end

      if (w_inc_p) begin
        case (r_state)
          S_SET_H: r_sh <= inc_wrap(r_sh, 6'd23);
          S_SET_M: r_sm <= inc_wrap(r_sm, 6'd59);
          S_SET_S: r_ss <= inc_wrap(r_ss, 6'd59);
          S_AL_H:  r_ah <= inc_wrap(r_ah, 6'd23);
          S_AL_M:  r_am <= inc_wrap(r_am, 6'd59);
          default: ;
        endcase
      end

      // Gate on the next state so no tick is ever seen while editing.
      if (w_edit_nx || w_load_nx) begin
        r_pre  <= '0;
        r_tick <= 1'b0;
      end else if (r_pre == PMAX) begin
        r_pre  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_pre  <= r_pre + PW'(1);
        r_tick <= 1'b0;
      end

      if (!alarm_en) begin
        r_alarm <= 1'b0;
      end else if (w_trig) begin
        r_alarm <= 1'b1;
        r_dur   <= '0;
      end else if (r_alarm && r_state == S_RUN && w_inc_p) begin
        r_alarm <= 1'b0;
      end else if (r_alarm && r_tick) begin
        if (r_dur == DLAST) r_alarm <= 1'b0;
        r_dur <= r_dur + DW'(1);
      end
    end
  end

  assign tick        = r_tick;
  assign load        = r_load;
  assign load_hours  = r_sh;
  assign load_min    = r_sm;
  assign load_sec    = r_ss;
  assign alarm_hours = r_ah;
  assign alarm_min   = r_am;
  assign mode        = r_state;
  assign alarm       = r_alarm;

endmodule

// File: tb/tb_clock_ctrl.sv
// Bench for clock_ctrl: time-anchored tick model and
// countdown alarm model checked every cycle, plus directed pins.
module tb_clock_ctrl;

  localparam int TD = 4;
  localparam int AL = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       alarm_en = 1'b0;
  logic [5:0] cur_hours = 6'd0;
  logic [5:0] cur_min = 6'd0;
  logic [5:0] cur_sec = 6'd0;
  logic       tick, load, alarm;
  logic [5:0] load_hours, load_min, load_sec;
  logic [5:0] alarm_hours, alarm_min;
  logic [2:0] mode;

  clock_ctrl #(.TICK_DIV(TD), .ALARM_LEN(AL)) dut (
    .clk(clk),
    .reset(reset),
    .btn_mode(btn_mode),
    .btn_inc(btn_inc),
    .alarm_en(alarm_en),
    .cur_hours(cur_hours),
    .cur_min(cur_min),
    .cur_sec(cur_sec),
    .tick(tick),
    .load(load),
    .load_hours(load_hours),
    .load_min(load_min),
    .load_sec(load_sec),
    .alarm_hours(alarm_hours),
    .alarm_min(alarm_min),
    .mode(mode),
    .alarm(alarm)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int edit_ticks = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // Behavioural model: ticks fall on multiples of TD edges
  // since the last anchor (reset or load); alarm counts down.
  int    m_mode, m_sh, m_sm, m_ss, m_ah, m_am, left;
  bit    m_tick, m_load, pm, pi, pmatch;
  longint cyc = 0;
  longint anchor = 0;
  bit    mp, ip, match, trig, otick;
  int    omode;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_tick = 0; m_load = 0;
      m_sh = 0; m_sm = 0; m_ss = 0;
      m_ah = 0; m_am = 0; left = 0;
      pm = 0; pi = 0; pmatch = 0;
      anchor = cyc;
    end else begin
      mp = btn_mode && !pm;
      ip = btn_inc && !pi && !mp;
      pm = btn_mode;
      pi = btn_inc;
      match = alarm_en && cur_hours == m_ah
           && cur_min == m_am && cur_sec == 0;
      trig = match && !pmatch;
      pmatch = match;
      otick = m_tick;
      omode = m_mode;
      m_load = 0;
      if (mp) begin
        if (omode == 0) begin
          m_sh = cur_hours; m_sm = cur_min; m_ss = cur_sec;
        end
        if (omode == 3) m_load = 1;
        m_mode = (omode + 1) % 6;
      end else if (ip) begin
        case (omode)
          1: m_sh = (m_sh + 1) % 24;
          2: m_sm = (m_sm + 1) % 60;
          3: m_ss = (m_ss + 1) % 60;
          4: m_ah = (m_ah + 1) % 24;
          5: m_am = (m_am + 1) % 60;
          default: ;
        endcase
      end
      cyc++;
      if (m_load) anchor = cyc;
      m_tick = (m_mode == 0 || m_mode >= 4) && !m_load
            && ((cyc - anchor) % TD == 0);
      if (!alarm_en) left = 0;
      else if (trig) left = AL;
      else if (left > 0 && omode == 0 && ip) left = 0;
      else if (left > 0 && otick) left--;
    end
  end

  always @(negedge clk) begin
    #1;
    chk("m_tick", tick, m_tick);
    chk("m_load", load, m_load);
    chk("m_mode", mode, m_mode);
    chk("m_lh", load_hours, m_sh);
    chk("m_lm", load_min, m_sm);
    chk("m_ls", load_sec, m_ss);
    chk("m_ah", alarm_hours, m_ah);
    chk("m_am", alarm_min, m_am);
    chk("m_alarm", alarm, left > 0);
    if (tick && mode >= 3'd1 && mode <= 3'd3) edit_ticks++;
  end

  task automatic nxt();
    @(negedge clk);
    #2;
  endtask

  task automatic press_mode();
    nxt();
    btn_mode = 1'b1;
    nxt();
    btn_mode = 1'b0;
  endtask

  task automatic press_inc();
    nxt();
    btn_inc = 1'b1;
    nxt();
    btn_inc = 1'b0;
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    cur_hours = 6'(h);
    cur_min = 6'(m);
    cur_sec = 6'(s);
  endtask

  int nt, lastk, k, first, loads, prev;

  initial begin
    nxt();
    chk("rst_mode", mode, 0);
    chk("rst_tick", tick, 0);
    chk("rst_load", load, 0);
    chk("rst_alarm", alarm, 0);
    nxt();
    reset = 1'b0;

    // Tick cadence over 40 cycles
    nt = 0; prev = -1; loads = 0;
    for (int i = 0; i < 40; i++) begin
      nxt();
      if (load) loads++;
      if (tick) begin
        if (prev >= 0) chk("tick_gap", i - prev, TD);
        prev = i;
        nt++;
      end
    end
    chk("tick_count", nt, 10);
    chk("tick_noload", loads, 0);

    // Set time from 12:34:56, hours wrap 23->0
    set_cur(12, 34, 56);
    press_mode();
    chk("seth_mode", mode, 1);
    chk("seth_copy", load_hours, 12);
    for (int i = 1; i <= 12; i++) begin
      press_inc();
      if (i == 11) chk("seth_23", load_hours, 23);
    end
    chk("seth_wrap", load_hours, 0);
    press_mode();
    press_mode();
    chk("sets_mode", mode, 3);
    press_mode();
    chk("ld_mode", mode, 4);
    chk("ld_pulse", load, 1);
    chk("ld_h", load_hours, 0);
    chk("ld_m", load_min, 34);
    chk("ld_s", load_sec, 56);
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      nxt();
      if (i == 1) chk("ld_width", load, 0);
      if (tick && first == 0) first = i;
    end
    chk("ld_first_tick", first, TD);

    // Alarm at 00:01, ALARM_LEN ticks
    press_mode();
    chk("alm_mode", mode, 5);
    press_inc();
    press_mode();
    chk("alm_run", mode, 0);
    chk("alm_h", alarm_hours, 0);
    chk("alm_m", alarm_min, 1);
    set_cur(0, 0, 59);
    alarm_en = 1'b1;
    nxt();
    chk("alm_pre", alarm, 0);
    set_cur(0, 1, 0);
    nxt();
    chk("alm_rise", alarm, 1);
    nt = tick ? 1 : 0;
    lastk = 0;
    for (k = 1; k <= 40; k++) begin
      nxt();
      if (!alarm) break;
      if (tick) begin
        nt++;
        lastk = k;
      end
    end
    chk("alm_ticks", nt, AL);
    chk("alm_fall_lag", k - lastk, 1);

    // Dismiss with inc in RUN
    set_cur(0, 0, 59);
    nxt();
    set_cur(0, 1, 0);
    nxt();
    chk("dis_rise", alarm, 1);
    btn_inc = 1'b1;
    nxt();
    btn_inc = 1'b0;
    chk("dis_clear", alarm, 0);
    chk("dis_mode", mode, 0);
    chk("dis_am", alarm_min, 1);
    chk("dis_lm", load_min, 34);
    chk("dis_ls", load_sec, 56);

    // alarm_en low clears alarm
    set_cur(0, 0, 59);
    nxt();
    set_cur(0, 1, 0);
    nxt();
    chk("en_rise", alarm, 1);
    alarm_en = 1'b0;
    nxt();
    chk("en_clear", alarm, 0);

    // Simultaneous mode+inc in SET_M
    press_mode();
    chk("sim_copy", load_min, 1);
    press_mode();
    chk("sim_setm", mode, 2);
    nxt();
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    nxt();
    chk("sim_mode", mode, 3);
    chk("sim_min", load_min, 1);
    repeat (10) nxt();
    chk("sim_hold_mode", mode, 3);
    chk("sim_hold_min", load_min, 1);
    btn_mode = 1'b0;
    btn_inc = 1'b0;

    // Async reset mid-edit
    press_inc();
    chk("rme_sec", load_sec, 1);
    reset = 1'b1;
    #1;
    chk("rme_mode", mode, 0);
    chk("rme_sec0", load_sec, 0);
    chk("rme_min0", load_min, 0);
    chk("rme_am0", alarm_min, 0);
    chk("rme_tick", tick, 0);
    chk("rme_load", load, 0);
    chk("rme_alarm", alarm, 0);
    nxt();
    nxt();
    reset = 1'b0;
    first = 0;
    loads = 0;
    for (int i = 1; i <= 10; i++) begin
      nxt();
      if (load) loads++;
      if (tick && first == 0) first = i;
    end
    chk("rme_noload", loads, 0);
    chk("rme_first_tick", first, TD);
    chk("edit_ticks", edit_ticks, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_ctrl.md
# clock_ctrl

Mode and sequencing controller for the 24-hour hours/min/sec timekeeping counter. Generates the counter's 1 Hz advance enable from the system clock and runs the button-driven set-time and set-alarm state machine. Issues a one-cycle parallel load of edited time into the counter and raises a timed alarm output on an hours/minutes match. Sits between the board push-buttons (already synchronised upstream) and the timekeeping counter.

## Interface
- TICK_DIV, 100_000_000, clk cycles per tick; must be ≥ 2
- ALARM_LEN, 60, ticks that `alarm` stays high once triggered; must be ≥ 1

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- btn_mode  in  1  mode button, level, already synchronous to clk
- btn_inc  in  1  increment/dismiss button, level, synchronous
- alarm_en  in  1  alarm arm switch, level
- cur_hours / cur_min / cur_sec  in  6 each  live counter values
- tick  out  1  one-cycle advance enable to the counter
- load  out  1  one-cycle parallel-load strobe to the counter
- load_hours / load_min / load_sec  out  6 each  shadow (edited) time; valid whenever `load`=1
- alarm_hours / alarm_min  out  6 each  stored alarm time
- mode  out  3  current state encoding
- alarm  out  1  alarm active

## Operation
- Button edges: btn_mode_q and btn_inc_q are registered copies of the buttons. A press is `btn & ~btn_q`, one cycle per rising edge; holding a button never repeats.
- States (`mode`): RUN=0, SET_H=1, SET_M=2, SET_S=3, AL_H=4, AL_M=5. Codes 6 and 7 are unreachable and return to RUN.
- Mode press advances RUN→SET_H→SET_M→SET_S→AL_H→AL_M→RUN.
- RUN→SET_H copies cur_hours/min/sec into the shadow registers on that edge.
- SET_S→AL_H registers `load`=1 for exactly one cycle with the shadow values. The prescaler is cleared on that same edge.
- Inc press edits the selected field with wrap-around:
  - SET_H: shadow hours, 23→0.
  - SET_M / SET_S: shadow min / sec, 59→0.
  - AL_H: alarm_hours, 23→0.
  - AL_M: alarm_min, 59→0.
- Mode press and inc press in the same cycle: the mode press wins and the inc press is dropped.
- Prescaler:
  - Counts 0..TICK_DIV-1 in RUN, AL_H and AL_M.
  - Registered `tick`=1 for one cycle each time it wraps from TICK_DIV-1 to 0.
  - In SET_H/SET_M/SET_S the prescaler is held at 0 and `tick`=0, so time is frozen while editing.
  - `tick` and `load` are never high in the same cycle.
- Alarm trigger:
  - match = alarm_en & (cur_hours==alarm_hours) & (cur_min==alarm_min) & (cur_sec==0).
  - A registered match_q gives a trigger on the rising edge of match, in any state.
  - Trigger sets `alarm`=1 and clears the duration counter.
- While `alarm`=1, each `tick` increments the duration counter. When ALARM_LEN ticks have elapsed, `alarm` drops.
- Dismiss: an inc press in RUN while `alarm`=1 clears `alarm` and does no other action.
- alarm_en=0 clears `alarm` on the next edge.
- A new trigger while `alarm`=1 restarts the duration count.
- Reset values, including reset asserted mid-edit or mid-alarm:
  - `mode`=RUN; tick, load, alarm = 0.
  - Shadow registers, alarm_hours, alarm_min, prescaler, duration counter, btn_*_q and match_q all 0.
  - Edits in progress are discarded and no `load` is issued.

## Timing
- Press latency: a button high at edge n with btn_q=0 changes `mode` or the edited field at edge n itself, so the effect is visible in the cycle after edge n.
- `load` is high in the same cycle that `mode` first reads AL_H.
- First `tick` after `load` comes TICK_DIV cycles later.
- Tick period is exactly TICK_DIV cycles with no drift across RUN↔AL_H/AL_M transitions.
- `alarm` rises one cycle after the match rising edge.
- `alarm` falls on the edge following the ALARM_LEN-th tick.
- Outputs are registered except `load_*`, `alarm_*` and `mode`, which are register contents driven directly.

## Test plan
- Tick cadence: TICK_DIV=4, hold RUN for 40 cycles. Expect 10 `tick` pulses, each exactly 4 cycles apart and 1 cycle wide. Expect `load`=0 throughout.
- Set time: start with cur=12:34:56. Press mode, then press inc 12 times. Expect shadow hours 12→23→0 (wrap). Continue to SET_S. Expect `load`=1 once with 00:34:56 as `mode` becomes 4. No `tick` while `mode` is 1–3.
- Alarm set and fire, ALARM_LEN=3: set alarm to 00:01 and arm alarm_en. Drive cur 00:00:59 then 00:01:00. Expect `alarm`=1 the next cycle and `alarm`=0 after the 3rd subsequent tick.
- Dismiss: alarm active in RUN. One inc press clears `alarm` the next cycle. Shadow and alarm registers are unchanged.
- Simultaneous presses: in SET_M, raise btn_mode and btn_inc on the same cycle. Expect `mode`=3 and shadow min unchanged. Holding both for 10 cycles gives no further change.
- Reset mid-edit: in SET_S with edited shadow, assert reset. Expect all outputs 0 and `mode`=0 immediately (asynchronous). No `load` after release. Ticks resume TICK_DIV cycles after reset deasserts.
